// File: rtl/vp_lsu_pkg.sv
// Shared constants and state type for the vector load/store unit.
package vp_lsu_pkg;

  localparam int unsigned VLEN_WORDS = 16;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned VEC_W      = 512;
  localparam int unsigned MEM_AW     = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/vp_lane_mask.sv
// Lane-valid mask for one beat: lane i is in range when ea+i < MEM_DEPTH.
// any_oob flags a beat that touches (or starts) beyond the end of memory.
module vp_lane_mask
  import vp_lsu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 512
) (
  input  logic [MEM_AW:0]       ea,
  output logic [VLEN_WORDS-1:0] lane_valid,
  output logic                  any_oob
);

  logic [MEM_AW+1:0] lane_ea;

  // Per-lane range test on an 11-bit sum so no lane address can wrap.
  always_comb begin
    lane_valid = '0;
    lane_ea    = '0;
    for (int unsigned i = 0; i < VLEN_WORDS; i++) begin
      lane_ea       = {1'b0, ea} + (MEM_AW+2)'(i);
      lane_valid[i] = lane_ea < (MEM_AW+2)'(MEM_DEPTH);
    end
    any_oob = ~&lane_valid;
  end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store controller: moves 1-4 consecutive 16-word vectors
// between the vector data memory and an external vector register file.
// Optional build macro: LSU_PERF_EN adds saturating executed-beat counters.
module vector_lsu
  import vp_lsu_pkg::*;
#(
  parameter int unsigned NUM_VREG  = 8,
  parameter int unsigned MEM_DEPTH = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_store,
  input  logic [MEM_AW-1:0] cmd_addr,
  input  logic [2:0]        cmd_vreg,
  input  logic [1:0]        cmd_count,
  output logic [2:0]        vrf_rd_addr,
  input  logic [VEC_W-1:0]  vrf_rd_data,
  output logic              vrf_wr_en,
  output logic [2:0]        vrf_wr_addr,
  output logic [VEC_W-1:0]  vrf_wr_data,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_w_enable,
  output logic [VEC_W-1:0]  mem_wdata,
  input  logic [VEC_W-1:0]  mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              oob
`ifdef LSU_PERF_EN
  ,
  output logic [15:0]       perf_load_beats,
  output logic [15:0]       perf_store_beats
`endif
);

  localparam logic [MEM_AW:0] BEAT_STEP = (MEM_AW+1)'(VLEN_WORDS);

  lsu_state_t            state_q, state_d;
  logic [MEM_AW:0]       ea_q;
  logic [1:0]            beat_q;
  logic [1:0]            count_q;
  logic [2:0]            vreg_q;
  logic                  oob_q;
  logic [VLEN_WORDS-1:0] lane_valid;
  logic                  any_oob;
  logic                  beat_live;
  logic [3:0]            vsum;
  logic [2:0]            vidx;

  vp_lane_mask #(
    .MEM_DEPTH (MEM_DEPTH)
  ) u_lane_mask (
    .ea         (ea_q),
    .lane_valid (lane_valid),
    .any_oob    (any_oob)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and all combinational outputs.
  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    vrf_wr_en    = 1'b0;
    mem_w_enable = 1'b0;
    vrf_wr_data  = '0;
    vsum         = {1'b0, vreg_q} + {2'b00, beat_q};
    vidx         = 3'(32'(vsum) % NUM_VREG);
    // Lane 0 in range is exactly "beat start address below MEM_DEPTH".
    beat_live    = lane_valid[0];
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = cmd_store ? STORE : LOAD;
      end
      LOAD: begin
        vrf_wr_en = beat_live;
        if (beat_q == count_q) state_d = DONE;
      end
      STORE: begin
        mem_w_enable = beat_live;
        if (beat_q == count_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    for (int unsigned i = 0; i < VLEN_WORDS; i++)
      vrf_wr_data[i*WORD_W +: WORD_W] = lane_valid[i] ? mem_rdata[i*WORD_W +: WORD_W] : '0;
    vrf_rd_addr = vidx;
    vrf_wr_addr = vidx;
    mem_wdata   = vrf_rd_data;
    mem_addr    = ea_q[MEM_AW-1:0];
    oob         = oob_q;
  end

  // Command latch, beat counter, beat address and sticky out-of-bounds flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ea_q    <= '0;
      beat_q  <= '0;
      count_q <= '0;
      vreg_q  <= '0;
      oob_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            ea_q    <= {1'b0, cmd_addr};
            beat_q  <= '0;
            count_q <= cmd_count;
            vreg_q  <= cmd_vreg;
            oob_q   <= 1'b0;
          end
        end
        LOAD, STORE: begin
          oob_q <= oob_q | any_oob;
          if (beat_q != count_q) begin
            beat_q <= beat_q + 2'd1;
            ea_q   <= ea_q + BEAT_STEP;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_PERF_EN
  // Saturating counters of beats that actually touched memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_load_beats  <= '0;
      perf_store_beats <= '0;
    end else begin
      if (vrf_wr_en && (perf_load_beats != '1))
        perf_load_beats <= perf_load_beats + 16'd1;
      if (mem_w_enable && (perf_store_beats != '1))
        perf_store_beats <= perf_store_beats + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu: table-driven directed commands,
// randomized commands against a lane-level reference model, and a
// mid-command reset sequence. Hosts the memory and VRF the LSU drives.
module tb_vector_lsu;

  localparam int NV = 8;
  localparam int MD = 512;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_store = 1'b0;
  logic [8:0]   cmd_addr = '0;
  logic [2:0]   cmd_vreg = '0;
  logic [1:0]   cmd_count = '0;
  logic         cmd_ready;
  logic [2:0]   vrf_rd_addr;
  logic [511:0] vrf_rd_data;
  logic         vrf_wr_en;
  logic [2:0]   vrf_wr_addr;
  logic [511:0] vrf_wr_data;
  logic [8:0]   mem_addr;
  logic         mem_w_enable;
  logic [511:0] mem_wdata;
  logic [511:0] mem_rdata;
  logic         busy;
  logic         done;
  logic         oob;
`ifdef LSU_PERF_EN
  logic [15:0]  perf_load_beats;
  logic [15:0]  perf_store_beats;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vector_lsu #(.NUM_VREG(8), .MEM_DEPTH(512)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_store    (cmd_store),
    .cmd_addr     (cmd_addr),
    .cmd_vreg     (cmd_vreg),
    .cmd_count    (cmd_count),
    .vrf_rd_addr  (vrf_rd_addr),
    .vrf_rd_data  (vrf_rd_data),
    .vrf_wr_en    (vrf_wr_en),
    .vrf_wr_addr  (vrf_wr_addr),
    .vrf_wr_data  (vrf_wr_data),
    .mem_addr     (mem_addr),
    .mem_w_enable (mem_w_enable),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .done         (done),
    .oob          (oob)
`ifdef LSU_PERF_EN
    ,
    .perf_load_beats  (perf_load_beats),
    .perf_store_beats (perf_store_beats)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    if (i < 12) return 32'(i);
    case (i)
      12: return 32'hFFFFFFFF;
      13: return 32'h80000000;
      14: return 32'h7FFFFFFF;
      15: return 32'h1FFFFFFF;
      28: return 32'hFFFFFFFF;
      29: return 32'h00FFFF00;
      30: return 32'h10000000;
      31: return 32'hEFFFFFFF;
      default: ;
    endcase
    if (i >= 16 && i < 28) return 32'(2000 + i - 16);
    return 32'h50000000 + 32'(i * 7);
  endfunction

  function automatic logic [31:0] init_lane(input int r, input int i);
    if (r == 1) return 32'hA0 + 32'(i);
    return 32'h10000000 * 32'(r + 1) + 32'(i * 3);
  endfunction

  // Environment: memory (combinational read, negedge write) and VRF.
  logic [31:0]  mem [MD];
  logic [511:0] vrf [NV];
  bit           mem_ready;
  bit           vrf_ready;

  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < MD; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_w_enable) begin
      for (int i = 0; i < 16; i++)
        if (int'(mem_addr) + i < MD) mem[int'(mem_addr) + i] <= mem_wdata[32*i +: 32];
    end
  end

  always @(posedge clk) begin
    if (!vrf_ready) begin
      for (int r = 0; r < NV; r++)
        for (int i = 0; i < 16; i++) vrf[r][32*i +: 32] <= init_lane(r, i);
      vrf_ready <= 1'b1;
    end else if (vrf_wr_en) begin
      vrf[vrf_wr_addr] <= vrf_wr_data;
    end
  end

  assign vrf_rd_data = vrf[vrf_rd_addr];

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      if (int'(mem_addr) + i < MD) mem_rdata[32*i +: 32] = mem[int'(mem_addr) + i];
      else                         mem_rdata[32*i +: 32] = 32'hDEADBEEF;
    end
  end

  // Reference model state.
  logic [31:0]  mem_m [MD];
  logic [511:0] vrf_m [NV];
  int           perf_ld_m = 0;
  int           perf_st_m = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < MD; i++) mem_m[i] = init_word(i);
    for (int r = 0; r < NV; r++)
      for (int i = 0; i < 16; i++) vrf_m[r][32*i +: 32] = init_lane(r, i);
  endtask

  // Word-level semantics of one command.
  task automatic model_cmd(input logic st, input int a, input int v, input int c,
                           output int e_wr, output int e_we, output logic e_oob);
    e_wr = 0; e_we = 0; e_oob = 1'b0;
    for (int b = 0; b <= c; b++) begin
      int ea, r;
      ea = a + 16 * b;
      r  = (v + b) % NV;
      if (ea + 15 >= MD) e_oob = 1'b1;
      if (ea < MD) begin
        if (st) begin e_we++; perf_st_m++; end
        else    begin e_wr++; perf_ld_m++; end
        for (int i = 0; i < 16; i++) begin
          if (st) begin
            if (ea + i < MD) mem_m[ea + i] = vrf_m[r][32*i +: 32];
          end else begin
            vrf_m[r][32*i +: 32] = (ea + i < MD) ? mem_m[ea + i] : 32'h0;
          end
        end
      end
    end
  endtask

  task automatic check_state(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < MD; i++)
      if (mem[i] !== mem_m[i]) begin
        if (bad == 0) $display("FAIL %s mem[%0d]: got %h expected %h", nm, i, mem[i], mem_m[i]);
        bad++;
      end
    for (int r = 0; r < NV; r++)
      if (vrf[r] !== vrf_m[r]) begin
        if (bad == 0) $display("FAIL %s vrf[%0d]: got %h expected %h", nm, r, vrf[r], vrf_m[r]);
        bad++;
      end
    n_cmp++;
    if (bad != 0) n_bad++;
  endtask

  // Issue one command and observe it to completion (bounded).
  task automatic run_cmd(input logic st, input logic [8:0] a, input logic [2:0] v,
                         input logic [1:0] c, output int n_wr, output int n_we,
                         output logic oob_after);
    int  j, done_at, b;
    bit  both;
    n_wr = 0; n_we = 0; done_at = -1; both = 1'b0;
    j = 0;
    while (!cmd_ready && j < 20) begin @(negedge clk); #1; j++; end
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_store = st; cmd_addr = a; cmd_vreg = v; cmd_count = c;
    @(posedge clk);
    j = 0;
    while (done_at < 0 && j < 12) begin
      @(negedge clk); #1; j++;
      if (vrf_wr_en) n_wr++;
      if (mem_w_enable) n_we++;
      if (vrf_wr_en && mem_w_enable) both = 1'b1;
      if (j == 1) begin
        check("busy_in_beat", busy, 1);
        check("oob_clear_on_accept", oob, 0);
        // Garbage on the command bus while busy must be ignored.
        cmd_store = $urandom_range(0, 1); cmd_addr = 9'($urandom);
        cmd_vreg = 3'($urandom); cmd_count = 2'($urandom);
      end
      if (j <= int'(c) + 1) begin
        b = j - 1;
        check("mem_addr", mem_addr, (int'(a) + 16 * b) % MD);
        if (st) check("vrf_rd_addr", vrf_rd_addr, (int'(v) + b) % NV);
        else    check("vrf_wr_addr", vrf_wr_addr, (int'(v) + b) % NV);
      end
      if (j == int'(c) + 1) cmd_valid = 1'b0;
      if (done) done_at = j;
    end
    check("done_latency", done_at, int'(c) + 2);
    check("no_dual_strobe", both, 0);
    @(negedge clk); #1;
    check("ready_after_done", cmd_ready, 1);
    check("done_one_pulse", done, 0);
    oob_after = oob;
  endtask

  typedef struct {
    logic       st;
    logic [8:0] a;
    logic [2:0] v;
    logic [1:0] c;
    int         wr;
    int         we;
    logic       oob;
  } vec_t;

  initial begin
    vec_t tbl [7];
    int   g_wr, g_we, e_wr, e_we;
    logic g_oob, e_oob;

    model_init();

    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_oob", oob, 0);
    check("rst_mem_w_enable", mem_w_enable, 0);
    check("rst_vrf_wr_en", vrf_wr_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b1;
    @(negedge clk); #1;

    tbl[0] = '{1'b0, 9'd0,   3'd2, 2'd0, 1, 0, 1'b0};
    tbl[1] = '{1'b0, 9'd0,   3'd7, 2'd1, 2, 0, 1'b0};
    tbl[2] = '{1'b1, 9'd32,  3'd1, 2'd0, 0, 1, 1'b0};
    tbl[3] = '{1'b0, 9'd32,  3'd4, 2'd0, 1, 0, 1'b0};
    tbl[4] = '{1'b0, 9'd504, 3'd5, 2'd1, 1, 0, 1'b1};
    tbl[5] = '{1'b1, 9'd500, 3'd6, 2'd3, 0, 1, 1'b1};
    tbl[6] = '{1'b0, 9'd100, 3'd6, 2'd3, 4, 0, 1'b0};

    for (int k = 0; k < 7; k++) begin
      model_cmd(tbl[k].st, int'(tbl[k].a), int'(tbl[k].v), int'(tbl[k].c), e_wr, e_we, e_oob);
      run_cmd(tbl[k].st, tbl[k].a, tbl[k].v, tbl[k].c, g_wr, g_we, g_oob);
      check("tbl_vrf_wr_beats", g_wr, tbl[k].wr);
      check("tbl_mem_w_beats", g_we, tbl[k].we);
      check("tbl_oob", g_oob, tbl[k].oob);
      check_state("tbl_state");
      case (k)
        0: begin
          check("t1_vrf2_lane3", vrf[2][32*3 +: 32], 32'd3);
          check("t1_vrf2_lane12", vrf[2][32*12 +: 32], 32'hFFFFFFFF);
          check("t1_vrf2_lane15", vrf[2][32*15 +: 32], 32'h1FFFFFFF);
        end
        1: begin
          check("t2_vrf0_lane0", vrf[0][31:0], 32'd2000);
          check("t2_vrf0_lane15", vrf[0][32*15 +: 32], 32'hEFFFFFFF);
        end
        3: check("t3_vrf4_lane5", vrf[4][32*5 +: 32], 32'hA5);
        4: begin
          check("t4_vrf5_lane7", vrf[5][32*7 +: 32], init_word(511));
          check("t4_vrf5_lane8_zero", vrf[5][32*8 +: 32], 32'h0);
        end
        default: ;
      endcase
    end

`ifdef LSU_PERF_EN
    check("perf_load_tbl", perf_load_beats, perf_ld_m);
    check("perf_store_tbl", perf_store_beats, perf_st_m);
`endif

    for (int k = 0; k < 40; k++) begin
      logic       st;
      logic [8:0] a;
      logic [2:0] v;
      logic [1:0] c;
      st = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(460, 511)) : 9'($urandom);
      v  = 3'($urandom);
      c  = 2'($urandom);
      model_cmd(st, int'(a), int'(v), int'(c), e_wr, e_we, e_oob);
      run_cmd(st, a, v, c, g_wr, g_we, g_oob);
      check("rnd_vrf_wr_beats", g_wr, e_wr);
      check("rnd_mem_w_beats", g_we, e_we);
      check("rnd_oob", g_oob, e_oob);
      check_state("rnd_state");
    end

`ifdef LSU_PERF_EN
    check("perf_load_rnd", perf_load_beats, perf_ld_m);
    check("perf_store_rnd", perf_store_beats, perf_st_m);
`endif

    // Reset asserted during beat 1 of a 4-beat store: only beat 0 lands.
    begin
      int j;
      j = 0;
      while (!cmd_ready && j < 20) begin @(negedge clk); #1; j++; end
      cmd_valid = 1'b1; cmd_store = 1'b1; cmd_addr = 9'd64; cmd_vreg = 3'd3; cmd_count = 2'd3;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("rst_mid_mem_w_enable", mem_w_enable, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_cmd_ready", cmd_ready, 1);
      check("rst_mid_mem_addr", mem_addr, 0);
      model_cmd(1'b1, 64, 3, 0, e_wr, e_we, e_oob);
      perf_ld_m = 0;
      perf_st_m = 0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      check_state("rst_mid_state");
`ifdef LSU_PERF_EN
      check("perf_load_after_rst", perf_load_beats, 0);
      check("perf_store_after_rst", perf_store_beats, 0);
`endif
    end

    model_cmd(1'b0, 64, 0, 1, e_wr, e_we, e_oob);
    run_cmd(1'b0, 9'd64, 3'd0, 2'd1, g_wr, g_we, g_oob);
    check("post_rst_vrf_wr_beats", g_wr, e_wr);
    check_state("post_rst_state");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
